// File: rtl/llc_req_in_queue_pkg.sv
// Shared request types and address field widths for the LLC request input queue.
// Imported by the queue top and its storage FIFO.
package llc_req_in_queue_pkg;

  localparam int LINE_ADDR_BITS = 16;
  localparam int LLC_SET_BITS   = 8;
  localparam int LLC_TAG_BITS   = LINE_ADDR_BITS - LLC_SET_BITS;
  localparam int WORDS_PER_LINE = 2;
  localparam int BITS_PER_LINE  = 64;
  localparam int REQ_ID_BITS    = 4;

  typedef enum logic [2:0] {
    REQ_GETS,
    REQ_GETM,
    REQ_PUTS,
    REQ_PUTM,
    REQ_DMA_READ,
    REQ_DMA_WRITE
  } coh_msg_t;

  typedef struct packed {
    coh_msg_t                  coh_msg;
    logic [1:0]                hprot;
    logic [LINE_ADDR_BITS-1:0] addr;
    logic [BITS_PER_LINE-1:0]  line;
    logic [WORDS_PER_LINE-1:0] word_mask;
    logic [REQ_ID_BITS-1:0]    req_id;
  } llc_req_in_packed_t;

  localparam int REQ_W = $bits(llc_req_in_packed_t);

endpackage

// File: rtl/llc_req_fifo.sv
// Generic DEPTH-entry FIFO: storage, wrapping pointers and occupancy count.
// Ready depends on count only, so a same-cycle pop never frees a full queue.
module llc_req_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [PTR_W:0]    count_o,
  output logic              ready_o,
  output logic              valid_o
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              push, pop;

  assign ready_o = (cnt_q != FULL);
  assign valid_o = (cnt_q != '0);
  assign push    = push_i & ready_o;
  assign pop     = pop_i & valid_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d  = pop ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + (PTR_W+1)'(1);
    else if (!push && pop)
      cnt_d = cnt_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/llc_req_in_queue.sv
// NoC request input queue with active and stalled request registers.
// LLC_REQ_QUEUE_STATS_EN adds hwm_o, full_cycles and empty_pop outputs.
module llc_req_in_queue
  import llc_req_in_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      llc_req_in_i_valid,
  output logic                      llc_req_in_i_ready,
  input  llc_req_in_packed_t        llc_req_in_i_data,
  output logic                      llc_req_in_valid,
  output logic [LINE_ADDR_BITS-1:0] req_in_addr,
  input  logic                      do_get_req,
  input  logic                      set_req_in_stalled,
  input  logic                      update_req_in_from_stalled,
  input  logic                      clr_req_in_stalled_valid,
  output llc_req_in_packed_t        req_in,
  output logic                      req_in_stalled_valid,
  output logic [LLC_SET_BITS-1:0]   req_in_stalled_set,
  output logic [LLC_TAG_BITS-1:0]   req_in_stalled_tag
`ifdef LLC_REQ_QUEUE_STATS_EN
  ,
  output logic [PTR_W:0]            hwm_o,
  output logic [31:0]               full_cycles,
  output logic                      empty_pop
`endif
);

  llc_req_in_packed_t head;
  llc_req_in_packed_t req_in_q, req_in_d;
  llc_req_in_packed_t stalled_q, stalled_d;
  logic               stalled_v_q, stalled_v_d;
  logic [PTR_W:0]     count;
  logic               pop_req, pop_fire;

  // Restore takes priority over a pop, so the FIFO is left untouched.
  assign pop_req  = do_get_req & ~update_req_in_from_stalled;
  assign pop_fire = pop_req & llc_req_in_valid;

  llc_req_fifo #(
    .DATA_W (REQ_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (llc_req_in_i_valid),
    .data_i  (llc_req_in_i_data),
    .pop_i   (pop_req),
    .data_o  (head),
    .count_o (count),
    .ready_o (llc_req_in_i_ready),
    .valid_o (llc_req_in_valid)
  );

  assign req_in_addr          = head.addr;
  assign req_in               = req_in_q;
  assign req_in_stalled_valid = stalled_v_q;
  assign req_in_stalled_set   = stalled_q.addr[LLC_SET_BITS-1:0];
  assign req_in_stalled_tag   = stalled_q.addr[LINE_ADDR_BITS-1:LLC_SET_BITS];

  always_comb begin
    req_in_d    = req_in_q;
    stalled_d   = stalled_q;
    stalled_v_d = stalled_v_q;
    if (update_req_in_from_stalled)
      req_in_d = stalled_q;
    else if (pop_fire)
      req_in_d = head;
    if (set_req_in_stalled) begin
      stalled_d   = req_in_q;
      stalled_v_d = 1'b1;
    end else if (clr_req_in_stalled_valid) begin
      stalled_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_in_q    <= '0;
      stalled_q   <= '0;
      stalled_v_q <= 1'b0;
    end else begin
      req_in_q    <= req_in_d;
      stalled_q   <= stalled_d;
      stalled_v_q <= stalled_v_d;
    end
  end

`ifdef LLC_REQ_QUEUE_STATS_EN
  logic [PTR_W:0] hwm_q, hwm_d;
  logic [31:0]    full_q, full_d;
  logic           epop_q, epop_d;

  always_comb begin
    hwm_d  = (count > hwm_q) ? count : hwm_q;
    full_d = full_q;
    if (count == (PTR_W+1)'(DEPTH) && full_q != '1)
      full_d = full_q + 32'd1;
    epop_d = epop_q | (do_get_req & ~llc_req_in_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwm_q  <= '0;
      full_q <= '0;
      epop_q <= 1'b0;
    end else begin
      hwm_q  <= hwm_d;
      full_q <= full_d;
      epop_q <= epop_d;
    end
  end

  assign hwm_o       = hwm_q;
  assign full_cycles = full_q;
  assign empty_pop   = epop_q;
`else
  a_no_empty_pop: assert property (
    @(posedge clk) disable iff (!rst)
    !(do_get_req && count == '0)
  );
`endif

endmodule

// File: tb/tb_llc_req_in_queue.sv
// Self-checking bench for llc_req_in_queue: vector table plus scoreboard.
// Stall/restore, conflicts and reset are driven as hand-written sequences.
module tb_llc_req_in_queue;
  import llc_req_in_queue_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  llc_req_in_packed_t        in_data = '0;
  logic                      q_valid;
  logic [LINE_ADDR_BITS-1:0] q_addr;
  logic                      get = 1'b0;
  logic                      set_st = 1'b0;
  logic                      upd = 1'b0;
  logic                      clr = 1'b0;
  llc_req_in_packed_t        req_in;
  logic                      st_valid;
  logic [LLC_SET_BITS-1:0]   st_set;
  logic [LLC_TAG_BITS-1:0]   st_tag;
`ifdef LLC_REQ_QUEUE_STATS_EN
  logic [2:0]                hwm;
  logic [31:0]               full_cycles;
  logic                      empty_pop;
`endif

  int n_chk = 0;
  int n_fail = 0;
  llc_req_in_packed_t sbq[$];

  llc_req_in_queue #(.DEPTH(4)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .llc_req_in_i_valid         (in_valid),
    .llc_req_in_i_ready         (in_ready),
    .llc_req_in_i_data          (in_data),
    .llc_req_in_valid           (q_valid),
    .req_in_addr                (q_addr),
    .do_get_req                 (get),
    .set_req_in_stalled         (set_st),
    .update_req_in_from_stalled (upd),
    .clr_req_in_stalled_valid   (clr),
    .req_in                     (req_in),
    .req_in_stalled_valid       (st_valid),
    .req_in_stalled_set         (st_set),
    .req_in_stalled_tag         (st_tag)
`ifdef LLC_REQ_QUEUE_STATS_EN
    ,
    .hwm_o                      (hwm),
    .full_cycles                (full_cycles),
    .empty_pop                  (empty_pop)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic llc_req_in_packed_t mk(input logic [15:0] a);
    llc_req_in_packed_t r;
    r           = '0;
    r.coh_msg   = REQ_GETM;
    r.hprot     = 2'b01;
    r.addr      = a;
    r.line      = {4{a}};
    r.word_mask = a[1:0];
    r.req_id    = a[3:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; the queue model decides acceptance on its own.
  task automatic cyc(input bit push, input logic [15:0] a, input bit pop,
                     input bit s, input bit u, input bit c);
    bit pp, acc;
    llc_req_in_packed_t exp;
    pp  = pop && (sbq.size() != 0) && !u;
    acc = push && (sbq.size() < 4);
    exp = '0;
    if (pp) exp = sbq.pop_front();
    if (acc) sbq.push_back(mk(a));
    in_valid = push;
    in_data  = mk(a);
    get      = pop;
    set_st   = s;
    upd      = u;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    get      = 1'b0;
    set_st   = 1'b0;
    upd      = 1'b0;
    clr      = 1'b0;
    if (pp) chk("pop_data", req_in, exp);
  endtask

  typedef struct {
    bit          push;
    logic [15:0] a;
    bit          pop;
    bit          er;
    bit          ev;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // fill, reject while full, drain
    tbl.push_back('{1'b1, 16'h0101, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 16'h0102, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 16'h0103, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 16'h0104, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 16'h0105, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 16'h0106, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0});
    // order
    tbl.push_back('{1'b1, 16'h0010, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 16'h0020, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 16'h0030, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0});
    // wrap at count 1
    tbl.push_back('{1'b1, 16'h0040, 1'b0, 1'b1, 1'b1});
    for (int k = 1; k <= 6; k++)
      tbl.push_back('{1'b1, 16'h0040 + 16'(k), 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", q_valid, 0);
    chk("rst_stalled_valid", st_valid, 0);
    chk("rst_req_in", req_in, 0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].push, tbl[i].a, tbl[i].pop, 0, 0, 0);
      chk($sformatf("ready[%0d]", i), in_ready, tbl[i].er);
      chk($sformatf("valid[%0d]", i), q_valid, tbl[i].ev);
      if (i == 4) chk("head_addr_full", q_addr, 16'h0101);
    end

    // stall and restore
    cyc(1, 16'h1234, 0, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    cyc(0, 16'h0000, 0, 1, 0, 0);
    chk("stall_valid", st_valid, 1);
    chk("stall_set", st_set, 8'h34);
    chk("stall_tag", st_tag, 8'h12);
    cyc(1, 16'h0055, 0, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    cyc(0, 16'h0000, 0, 0, 1, 0);
    chk("restore_req", req_in, mk(16'h1234));

    // conflicts
    cyc(0, 16'h0000, 0, 0, 0, 1);
    chk("clr_valid", st_valid, 0);
    chk("clr_keeps_set", st_set, 8'h34);
    cyc(0, 16'h0000, 0, 1, 0, 1);
    chk("set_over_clr", st_valid, 1);
    cyc(1, 16'h0077, 0, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 1, 0);
    chk("upd_over_get_req", req_in, mk(16'h1234));
    chk("upd_over_get_valid", q_valid, 1);
    chk("upd_over_get_head", q_addr, 16'h0077);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    chk("after_upd_empty", q_valid, 0);

    // asynchronous reset mid-operation
    cyc(1, 16'h00a1, 0, 0, 0, 0);
    cyc(1, 16'h00a2, 0, 0, 0, 0);
    cyc(1, 16'h00a3, 0, 0, 0, 0);
    chk("pre_rst_stalled", st_valid, 1);
    rst = 1'b0;
    #2;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_valid", q_valid, 0);
    chk("mid_rst_stalled", st_valid, 0);
    chk("mid_rst_req_in", req_in, 0);
    chk("mid_rst_set", st_set, 0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 16'h00b0, 0, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    chk("post_rst_empty", q_valid, 0);

`ifdef LLC_REQ_QUEUE_STATS_EN
    cyc(0, 16'h0000, 1, 0, 0, 0);
    chk("empty_pop", empty_pop, 1);
    for (int k = 0; k < 4; k++)
      cyc(1, 16'h00c0 + 16'(k), 0, 0, 0, 0);
    cyc(0, 16'h0000, 0, 0, 0, 0);
    chk("hwm", hwm, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
